mitll_ndro_bank: RTL

MITLL_NDRO_BANK -- requirements
Module: mitll_ndro_bank

---
 rtl/mitll_ndro_pkg.sv | 14 +
 rtl/mitll_ndro_cell.sv | 53 +++++
 rtl/mitll_ndro_bank.sv | 56 +++++
 3 files changed

// File: rtl/mitll_ndro_pkg.sv
// rtl/mitll_ndro_pkg.sv - shared state encoding and default parameters for the NDRO bank
package mitll_ndro_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } ndro_state_e;

    localparam int DEF_WIDTH        = 4;
    localparam bit DEF_DESTRUCTIVE  = 1'b0;
    localparam bit DEF_CLR_PRIORITY = 1'b1;
    localparam int DEF_CNT_W        = 8;

endpackage

// File: rtl/mitll_ndro_cell.sv
// rtl/mitll_ndro_cell.sv - one NDRO storage channel with clear/conflict pulses and optional read-clear
module mitll_ndro_cell
    import mitll_ndro_pkg::*;
#(
    parameter bit DESTRUCTIVE  = DEF_DESTRUCTIVE,
    parameter bit CLR_PRIORITY = DEF_CLR_PRIORITY
) (
    input  logic clk,
    input  logic reset,
    input  logic set,
    input  logic clr,
    input  logic rd,
    output logic state,
    output logic resout,
    output logic conflict
);

    ndro_state_e state_q;
    ndro_state_e state_d;
    logic        clr_wins;
    logic        resout_d;
    logic        conflict_d;

    always_comb begin
        clr_wins   = clr && (CLR_PRIORITY || !set);
        state_d    = state_q;
        // Explicit set beats read-clear; read-clear never raises resout.
        if (clr_wins) begin
            state_d = EMPTY;
        end else if (set) begin
            state_d = HELD;
        end else if (DESTRUCTIVE && rd) begin
            state_d = EMPTY;
        end
        resout_d   = clr_wins && (state_q == HELD);
        conflict_d = set && clr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= EMPTY;
            resout   <= 1'b0;
            conflict <= 1'b0;
        end else begin
            state_q  <= state_d;
            resout   <= resout_d;
            conflict <= conflict_d;
        end
    end

    assign state = (state_q == HELD);

endmodule

// File: rtl/mitll_ndro_bank.sv
// rtl/mitll_ndro_bank.sv - bank of NDRO channels with registered readout and saturating read counter
module mitll_ndro_bank
    import mitll_ndro_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter bit DESTRUCTIVE  = DEF_DESTRUCTIVE,
    parameter bit CLR_PRIORITY = DEF_CLR_PRIORITY,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] set,
    input  logic [WIDTH-1:0] clr,
    input  logic             rd,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic [WIDTH-1:0] resout,
    output logic [WIDTH-1:0] conflict,
    output logic [WIDTH-1:0] state,
    output logic [CNT_W-1:0] rd_count
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        mitll_ndro_cell #(
            .DESTRUCTIVE  (DESTRUCTIVE),
            .CLR_PRIORITY (CLR_PRIORITY)
        ) u_cell (
            .clk      (clk),
            .reset    (reset),
            .set      (set[i]),
            .clr      (clr[i]),
            .rd       (rd),
            .state    (state[i]),
            .resout   (resout[i]),
            .conflict (conflict[i])
        );
    end

    // out samples the cells' pre-edge state, so same-edge updates show on the next read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out       <= '0;
            out_valid <= 1'b0;
            rd_count  <= '0;
        end else begin
            out_valid <= rd;
            if (rd) begin
                out <= state;
                if (rd_count != {CNT_W{1'b1}}) begin
                    rd_count <= rd_count + CNT_W'(1);
                end
            end
        end
    end

endmodule
